// File: rtl/psum_drain_ctrl.sv
// Psum drain/accumulate sequencer: moves OFIFO vectors into the psum SRAM (DRAIN)
// or streams a run of stored vectors back to the SFU bank with an accum strobe (ACC).
module psum_drain_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned addr_w  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_drain,
  input  logic                   start_acc,
  input  logic [addr_w-1:0]      base_addr,
  input  logic [addr_w:0]        len,
  input  logic                   ofifo_valid,
  input  logic [psum_bw*col-1:0] ofifo_data,
  output logic                   ofifo_rd,
  output logic                   mem_en,
  output logic                   mem_wen,
  output logic [addr_w-1:0]      mem_addr,
  output logic [psum_bw*col-1:0] mem_wdata,
  input  logic [psum_bw*col-1:0] mem_rdata,
  output logic                   accum,
  output logic [psum_bw*col-1:0] acc_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {StIdle, StDrain, StAcc, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [addr_w:0]   cnt_q, cnt_d;
  logic [addr_w:0]   len_q, len_d;
  logic [addr_w-1:0] base_q, base_d;
  logic              rd_pend_q;
  logic              last;
  logic [addr_w-1:0] cur_addr;

  assign last     = (cnt_q == len_q - (addr_w+1)'(1));
  // Address wraps naturally at the SRAM depth.
  assign cur_addr = base_q + cnt_q[addr_w-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    base_d    = base_q;
    ofifo_rd  = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    busy      = (state_q != StIdle);
    accum     = rd_pend_q;
    acc_data  = rd_pend_q ? mem_rdata : '0;

    unique case (state_q)
      StIdle: begin
        // Drain has priority; a simultaneous acc request is dropped.
        if (start_drain || start_acc) begin
          base_d  = base_addr;
          len_d   = len;
          cnt_d   = '0;
          if (len == '0) begin
            state_d = StDone;
          end else begin
            state_d = start_drain ? StDrain : StAcc;
          end
        end
      end
      StDrain: begin
        if (ofifo_valid) begin
          ofifo_rd  = 1'b1;
          mem_en    = 1'b1;
          mem_wen   = 1'b1;
          mem_addr  = cur_addr;
          mem_wdata = ofifo_data;
          cnt_d     = cnt_q + (addr_w+1)'(1);
          if (last) state_d = StDone;
        end
      end
      StAcc: begin
        mem_en   = 1'b1;
        mem_addr = cur_addr;
        cnt_d    = cnt_q + (addr_w+1)'(1);
        if (last) state_d = StFlush;
      end
      StFlush: state_d = StDone;
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are held quiet for the whole reset cycle, not just after it.
    if (!reset) begin
      ofifo_rd  = 1'b0;
      mem_en    = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      accum     = 1'b0;
      acc_data  = '0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      rd_pend_q <= (state_q == StAcc);
    end
  end

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Scoreboard bench for psum_drain_ctrl: drivers push expected SRAM writes, reads, accum
// beats and done pulses (with cycle stamps) into queues; a monitor pops and compares.
module tb_psum_drain_ctrl;

  localparam int unsigned Col    = 8;
  localparam int unsigned PsumBw = 16;
  localparam int unsigned AddrW  = 4;
  localparam int unsigned DW     = Col * PsumBw;
  localparam int unsigned Depth  = 1 << AddrW;

  logic             clk;
  logic             reset;
  logic             start_drain;
  logic             start_acc;
  logic [AddrW-1:0] base_addr;
  logic [AddrW:0]   len;
  logic             ofifo_valid;
  logic [DW-1:0]    ofifo_data;
  logic             ofifo_rd;
  logic             mem_en;
  logic             mem_wen;
  logic [AddrW-1:0] mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             accum;
  logic [DW-1:0]    acc_data;
  logic             busy;
  logic             done;

  psum_drain_ctrl #(
    .col     (Col),
    .psum_bw (PsumBw),
    .addr_w  (AddrW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_drain (start_drain),
    .start_acc   (start_acc),
    .base_addr   (base_addr),
    .len         (len),
    .ofifo_valid (ofifo_valid),
    .ofifo_data  (ofifo_data),
    .ofifo_rd    (ofifo_rd),
    .mem_en      (mem_en),
    .mem_wen     (mem_wen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .accum       (accum),
    .acc_data    (acc_data),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int               cyc;
    logic [AddrW-1:0] addr;
    logic [DW-1:0]    data;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_rd[$];
  ev_t q_acc[$];
  int  q_done[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] ref_mem [Depth];
  logic [DW-1:0] sram    [Depth];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_wen) mem_rdata <= sram[mem_addr];
  end

  function automatic logic [DW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input int now);
    checks++;
    errors++;
    $display("FAIL unexpected_%s: event in cycle %0d, expected none", name, now);
  endtask

  task automatic check_zero(input string name);
    chk(name, DW'(|{ofifo_rd, mem_en, mem_wen, accum, busy, done, mem_addr, mem_wdata,
                    acc_data}), DW'(0));
  endtask

  // Monitor: samples 2 time units after the falling edge, once inputs have settled.
  initial begin
    int   now;
    ev_t  e;
    logic bad;
    forever begin
      @(negedge clk);
      #2;
      now = cyc + 1;
      if (mem_en === 1'b1 && mem_wen === 1'b1) begin
        if (q_wr.size() == 0) unexpected("write", now);
        else begin
          e = q_wr.pop_front();
          chk("wr_addr", DW'(mem_addr), DW'(e.addr));
          chk("wr_data", mem_wdata, e.data);
          chk("wr_cycle", DW'(now), DW'(e.cyc));
          chk("wr_ofifo_rd", DW'(ofifo_rd), DW'(1));
        end
      end
      if (mem_en === 1'b1 && mem_wen === 1'b0) begin
        if (q_rd.size() == 0) unexpected("read", now);
        else begin
          e = q_rd.pop_front();
          chk("rd_addr", DW'(mem_addr), DW'(e.addr));
          chk("rd_cycle", DW'(now), DW'(e.cyc));
        end
      end
      if (accum === 1'b1) begin
        if (q_acc.size() == 0) unexpected("accum", now);
        else begin
          e = q_acc.pop_front();
          chk("acc_data", acc_data, e.data);
          chk("acc_cycle", DW'(now), DW'(e.cyc));
        end
      end
      if (done === 1'b1) begin
        if (q_done.size() == 0) unexpected("done", now);
        else chk("done_cycle", DW'(now), DW'(q_done.pop_front()));
      end
      bad = (ofifo_rd && !(mem_en && mem_wen)) ||
            (!mem_en && (mem_wen || mem_addr != '0 || mem_wdata != '0)) ||
            (mem_en && !mem_wen && mem_wdata != '0) ||
            (!accum && acc_data != '0);
      chk("quiet_outputs", DW'(bad), DW'(0));
    end
  end

  task automatic run_drain(input logic [AddrW-1:0] b, input int l, input int vpct,
                           input logic [31:0] pat, input int npat, input bit with_acc,
                           input bit poke);
    int               e;
    int               k;
    logic             v;
    logic [DW-1:0]    d;
    logic [AddrW-1:0] a;
    @(negedge clk);
    start_drain = 1'b1;
    start_acc   = with_acc;
    base_addr   = b;
    len         = (AddrW+1)'(l);
    ofifo_valid = 1'($urandom_range(0, 1));
    ofifo_data  = rand_vec();
    e = cyc + 1;
    if (l == 0) q_done.push_back(e + 1);
    k = 0;
    for (int i = 0; k < l || i == 0; i++) begin
      @(negedge clk);
      start_drain = 1'b0;
      start_acc   = poke && (i == 0);
      if (k < l) v = (i < npat) ? pat[i] : ($urandom_range(0, 99) < vpct);
      else v = 1'($urandom_range(0, 1));
      d = rand_vec();
      ofifo_valid = v;
      ofifo_data  = d;
      if (v && k < l) begin
        a = b + AddrW'(k);
        q_wr.push_back('{cyc: cyc + 1, addr: a, data: d});
        ref_mem[a] = d;
        k++;
        if (k == l) q_done.push_back(cyc + 2);
      end
      if (i == 0) begin
        #1;
        chk("busy_running", DW'(busy), DW'(1));
      end
    end
  endtask

  // rst_after < 0: normal run; otherwise reset is pulled low after that many reads.
  task automatic run_acc(input logic [AddrW-1:0] b, input int l, input int rst_after);
    int               e;
    int               nrd;
    logic [AddrW-1:0] a;
    @(negedge clk);
    start_acc   = 1'b1;
    start_drain = 1'b0;
    base_addr   = b;
    len         = (AddrW+1)'(l);
    e = cyc + 1;
    nrd = (rst_after >= 0) ? rst_after : l;
    for (int k = 0; k < nrd; k++) begin
      a = b + AddrW'(k);
      q_rd.push_back('{cyc: e + 1 + k, addr: a, data: '0});
      if (rst_after < 0 || k < nrd - 1) q_acc.push_back('{cyc: e + 2 + k, addr: a, data: ref_mem[a]});
    end
    if (rst_after < 0) q_done.push_back((l == 0) ? e + 1 : e + l + 2);
    @(negedge clk);
    start_acc = 1'b0;
    #1;
    chk("busy_running", DW'(busy), DW'(1));
    if (rst_after >= 0) begin
      repeat (nrd) @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero("outputs_in_reset");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_zero("outputs_after_reset");
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q_wr.size() + q_rd.size() + q_acc.size() + q_done.size()) != 0 && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    if ((q_wr.size() + q_rd.size() + q_acc.size() + q_done.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d writes, %0d reads, %0d accums, %0d dones still pending",
               name, q_wr.size(), q_rd.size(), q_acc.size(), q_done.size());
      q_wr.delete();
      q_rd.delete();
      q_acc.delete();
      q_done.delete();
    end
    @(negedge clk);
    #3;
    chk({"busy_idle_", name}, DW'(busy), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    start_drain = 1'b0;
    start_acc   = 1'b0;
    base_addr   = '0;
    len         = '0;
    ofifo_valid = 1'b0;
    ofifo_data  = '0;
    for (int i = 0; i < Depth; i++) begin
      ref_mem[i] = rand_vec();
      sram[i]   <= ref_mem[i];
    end
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b1;

    run_drain(4'd2, 3, 100, 32'h0, 0, 1'b0, 1'b0);
    wait_idle("drain_basic");
    run_drain(4'd5, 3, 100, 32'b11001, 5, 1'b0, 1'b0);
    wait_idle("drain_gaps");
    run_acc(4'd14, 4, -1);
    wait_idle("acc_wrap");
    run_drain(4'd8, 4, 100, 32'h0, 0, 1'b1, 1'b1);
    wait_idle("drain_wins");
    run_drain(4'd3, 0, 100, 32'h0, 0, 1'b0, 1'b0);
    wait_idle("drain_len0");
    run_acc(4'd3, 0, -1);
    wait_idle("acc_len0");
    run_acc(4'd0, 6, 2);
    wait_idle("acc_reset");
    run_acc(4'd0, 6, -1);
    wait_idle("acc_after_reset");
    run_drain(4'd10, 16, 70, 32'h0, 0, 1'b0, 1'b0);
    wait_idle("drain_full");
    run_acc(4'd10, 16, -1);
    wait_idle("acc_full");

    repeat (40) begin
      if ($urandom_range(0, 1) == 1)
        run_drain(AddrW'($urandom_range(0, Depth - 1)), $urandom_range(0, Depth),
                  $urandom_range(30, 100), 32'h0, 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      else
        run_acc(AddrW'($urandom_range(0, Depth - 1)), $urandom_range(0, Depth), -1);
      wait_idle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_drain_ctrl.md
# psum_drain_ctrl

Sequencer between the corelet's output FIFO / SFU and the partial-sum SRAM. In DRAIN mode it pops column-psum vectors from the OFIFO and writes them to consecutive SRAM addresses. In ACC mode it reads a run of stored vectors back and presents them to the SFU bank with the `accum` strobe. One engine, one mode at a time, with busy/done handshake to the top-level controller.

## Interface
Parameters:
- `col`, 8, number of columns per psum vector
- `psum_bw`, 16, bits per column psum
- `addr_w`, 4, SRAM address width (depth 2^addr_w)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `start_drain`  in  1  one-cycle request: drain `len` vectors to SRAM
- `start_acc`  in  1  one-cycle request: read `len` vectors to SFU
- `base_addr`  in  addr_w  first SRAM address, sampled on accepted start
- `len`  in  addr_w+1  vector count, 0..2^addr_w, sampled on accepted start
- `ofifo_valid`  in  1  OFIFO head valid (first-word-fall-through)
- `ofifo_data`  in  psum_bw*col  OFIFO head vector
- `ofifo_rd`  out  1  pop OFIFO head at this edge
- `mem_en`  out  1  SRAM access this cycle
- `mem_wen`  out  1  1 = write, 0 = read (meaningful only with `mem_en`)
- `mem_addr`  out  addr_w  SRAM address
- `mem_wdata`  out  psum_bw*col  SRAM write data
- `mem_rdata`  in  psum_bw*col  SRAM read data, valid one cycle after read
- `accum`  out  1  SFU accumulate strobe
- `acc_data`  out  psum_bw*col  vector to SFU bank
- `busy`  out  1  engine not IDLE
- `done`  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, DRAIN, ACC, FLUSH, DONE.
- IDLE:
  - `start_drain` -> DRAIN.
  - `start_acc` -> ACC.
  - Both asserted: drain wins, `start_acc` is dropped.
  - On an accepted start, latch `base_addr`/`len` and clear `cnt`.
  - `len`==0: go directly to DONE.
- Starts seen outside IDLE are ignored (not queued).
- DRAIN:
  - `ofifo_rd` = `mem_en` = `mem_wen` = `ofifo_valid`.
  - `mem_addr` = base+cnt, mod 2^addr_w (wraps).
  - `mem_wdata` = `ofifo_data`.
  - `cnt` increments on each write.
  - The write with cnt==len-1 goes to DONE.
  - No `ofifo_valid`: stall, no access, stay in DRAIN indefinitely.
- ACC:
  - Issue one read every cycle: `mem_en`=1, `mem_wen`=0, addr = base+cnt with wrap.
  - The read with cnt==len-1 goes to FLUSH.
- Read pipeline: register `rd_pend` <= (state==ACC). Then `accum` = `rd_pend` and `acc_data` = `mem_rdata` (combinational pass-through).
- FLUSH: one cycle, no access, last `accum` is emitted. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `busy`=0 only in IDLE.
- Outputs not listed for a state are 0, including data buses (`mem_wdata`, `acc_data` forced 0 when their qualifier is low).
- Reset active (low at an edge):
  - state=IDLE, cnt=0, `rd_pend`=0.
  - All outputs 0 in the following cycle.
  - Any in-flight drain/acc is abandoned; no `done` pulse.

## Timing
- All outputs are 0 during and immediately after reset.
- DRAIN:
  - Start at edge E: first write possible in cycle E+1 (same cycle as `ofifo_valid`, zero added latency).
  - Uninterrupted: last write cycle E+len, `done` at E+len+1.
- ACC:
  - Start at edge E: reads in cycles E+1..E+len.
  - `accum` in cycles E+2..E+len+1, each one cycle after its read.
  - `done` at E+len+2.
- `len`==0: `done` at E+1, no memory access.
- Throughput: one vector per cycle in both modes.

## Test plan
- Drain, base=2, len=3, OFIFO always valid holding A,B,C -> writes A@2, B@3, C@4 on consecutive cycles, 3 `ofifo_rd` pulses, `done` one cycle after C, `busy` low after.
- Drain with gaps: `ofifo_valid` pattern 1,0,0,1,1, len=3 -> exactly 3 writes on valid cycles only, addresses contiguous, `done` the cycle after the 3rd write.
- Acc, base=14, len=4, addr_w=4 -> reads 14,15,0,1; `accum` high 4 consecutive cycles starting one cycle after the first read, `acc_data` = stored vectors in order; `done` 2 cycles after the last read.
- `start_drain` and `start_acc` together, then `start_acc` while busy -> only the drain runs, no reads issued, the second start is ignored.
- `len`=0 -> `done` the next cycle, `mem_en`/`ofifo_rd`/`accum` never assert.
- Reset low in mid-ACC after 2 reads -> next cycle all outputs 0, no `done`, no further `accum`; a new start after reset runs normally.
